// File: rtl/csa_accum_ctrl.sv
// Carry-save accumulator controller: sums an operand stream in redundant form, then resolves it with one add.
// Optional build macro CSA_ACC_OVF_EN adds guard bits and the out_ovf port.
module csa_accum_ctrl #(
  parameter int WIDTH   = 8,
  parameter int MAX_OPS = 16,
  localparam int CW     = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_trunc
`ifdef CSA_ACC_OVF_EN
  ,
  output logic             out_ovf
`endif
);

`ifdef CSA_ACC_OVF_EN
  localparam int AW = WIDTH + CW;
`else
  localparam int AW = WIDTH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESOLVE, S_OUT} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [AW-1:0]    r_sum;
  // The cout MSB would be shifted out on feedback, so only the lower bits are stored.
  logic [AW-2:0]    r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_out_count;
  logic             r_out_trunc;

  logic [AW-1:0]    w_opnd;
  logic [AW-1:0]    w_x;
  logic [AW-1:0]    w_y;
  logic [AW-1:0]    w_s;
  logic [AW-2:0]    w_cout;
  logic [AW-1:0]    w_resolved;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_close;
  logic             w_accept;
  logic             w_in_ready;
  logic             w_out_valid;

`ifdef CSA_ACC_OVF_EN
  logic r_out_ovf;
  assign w_opnd  = {{CW{1'b0}}, in_data};
  assign out_ovf = r_out_ovf;
`else
  assign w_opnd = in_data;
`endif

  // A batch starts from zero in IDLE regardless of what the registers hold.
  assign w_x       = (r_state == S_IDLE) ? '0 : r_sum;
  assign w_y       = (r_state == S_IDLE) ? '0 : {r_carry, 1'b0};
  assign w_s       = w_x ^ w_y ^ w_opnd;
  assign w_cout    = (w_x[AW-2:0] & w_y[AW-2:0]) | (w_x[AW-2:0] & w_opnd[AW-2:0]) |
                     (w_y[AW-2:0] & w_opnd[AW-2:0]);
  assign w_resolved = r_sum + {r_carry, 1'b0};
  assign w_cnt_inc = (r_state == S_IDLE) ? CW'(1) : r_cnt + CW'(1);
  assign w_close   = in_last || (w_cnt_inc == CW'(MAX_OPS));
  assign w_accept  = in_valid && w_in_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_trunc = r_out_trunc;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_next = w_close ? S_RESOLVE : S_ACC;
      end
      S_ACC: begin
        w_in_ready = 1'b1;
        if (in_valid && w_close) w_state_next = S_RESOLVE;
      end
      S_RESOLVE: w_state_next = S_OUT;
      S_OUT: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sum       <= '0;
      r_carry     <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_trunc <= 1'b0;
`ifdef CSA_ACC_OVF_EN
      r_out_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (w_accept) begin
            r_sum   <= w_s;
            r_carry <= w_cout;
            r_cnt   <= w_cnt_inc;
            if (w_close) r_out_trunc <= ~in_last;
          end
        end
        S_RESOLVE: begin
          r_out_data  <= w_resolved[WIDTH-1:0];
          r_out_count <= r_cnt;
`ifdef CSA_ACC_OVF_EN
          r_out_ovf   <= |w_resolved[AW-1:WIDTH];
`endif
        end
        S_OUT: begin
          if (out_ready) begin
            r_sum   <= '0;
            r_carry <= '0;
            r_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Scoreboard bench for csa_accum_ctrl (WIDTH=8, MAX_OPS=16): directed cases followed by random batches.
module tb_csa_accum_ctrl;
  localparam int W  = 8;
  localparam int M  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_trunc;
`ifdef CSA_ACC_OVF_EN
  logic          out_ovf;
`endif

  csa_accum_ctrl #(.WIDTH(W), .MAX_OPS(M)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_trunc (out_trunc)
`ifdef CSA_ACC_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;
    logic          trunc;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pushed = 0;
  int   n_out = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  int   sw_sum = 0;
  int   sw_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one operand, hold it until accepted, then update the reference model.
  task automatic send_op(input logic [W-1:0] d, input bit last, input int gap);
    bit hs;
    int waited;
    in_valid = 1'b0;
    repeat (gap) begin
      in_data = W'($urandom);
      in_last = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    hs = 1'b0;
    waited = 0;
    while (!hs) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
      waited++;
      if (!hs && waited > 200) begin
        check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    sw_sum += int'(d);
    sw_cnt++;
    if (last || sw_cnt == M) begin
      exp_t e;
      e.data  = sw_sum[W-1:0];
      e.cnt   = sw_cnt[CW-1:0];
      e.trunc = !last;
      e.ovf   = (sw_sum > 255);
      exp_q.push_back(e);
      n_pushed++;
      sw_sum = 0;
      sw_cnt = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rstn && out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_count", 32'(out_count), 32'(e.cnt));
          check("out_trunc", 32'(out_trunc), 32'(e.trunc));
`ifdef CSA_ACC_OVF_EN
          check("out_ovf", 32'(out_ovf), 32'(e.ovf));
`endif
        end
      end
    end
  end

  initial begin
    int len;
    int waited;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_count", 32'(out_count), 0);
    check("rst_trunc", 32'(out_trunc), 0);
    check("rst_ready", 32'(in_ready), 1);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Reset mid-batch discards the partial sum.
    send_op(8'd4, 1'b0, 0);
    send_op(8'd6, 1'b0, 0);
    rstn = 1'b0;
    sw_sum = 0;
    sw_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_data", 32'(out_data), 0);
    check("midrst_count", 32'(out_count), 0);
    check("midrst_ready", 32'(in_ready), 1);
    rstn = 1'b1;
    send_op(8'd9, 1'b1, 1);
    repeat (4) @(posedge clk);
    #1;

    // 3,5,7: out_valid rises two cycles after the cycle the last beat is presented.
    send_op(8'd3, 1'b0, 0);
    send_op(8'd5, 1'b0, 0);
    send_op(8'd7, 1'b1, 0);
    check("lat_resolve_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_out_valid", 32'(out_valid), 1);
    check("sum357", 32'(out_data), 15);
    repeat (2) @(posedge clk);
    #1;

    send_op(8'd200, 1'b0, 0);
    send_op(8'd100, 1'b1, 0);
    @(posedge clk); #1;
    check("wrap_data", 32'(out_data), 44);
    repeat (2) @(posedge clk);
    #1;

    // Sixteen ones without in_last close on the limit; a 17th beat must wait.
    for (int i = 0; i < M; i++) send_op(8'd1, 1'b0, 0);
    in_valid = 1'b1;
    in_data  = 8'd1;
    in_last  = 1'b1;
    check("full_rdy_resolve", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("full_rdy_out", 32'(in_ready), 0);
    check("full_count", 32'(out_count), 16);
    check("full_trunc", 32'(out_trunc), 1);
    in_valid = 1'b0;
    send_op(8'd1, 1'b1, 0);
    repeat (4) @(posedge clk);
    #1;

    // Single-operand batch held by back-pressure.
    rdy_mode = 2;
    @(posedge clk); #1;
    send_op(8'hA5, 1'b1, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(out_valid), 1);
      check("hold_data", 32'(out_data), 32'hA5);
      check("hold_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    rdy_mode = 1;
    for (int b = 0; b < 1000; b++) begin
      len = $urandom_range(1, 18);
      for (int i = 0; i < len; i++)
        send_op(W'($urandom), (i == len - 1), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    rdy_mode = 0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 0);
    check("out_total", 32'(n_out), 32'(n_pushed));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
